// File: rtl/crg_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// crg_clk_switch_ctrl : select sequencer for a glitch-free clk_a/clk_b mux
// Revision: 1.0
// ============================================================================
module crg_clk_switch_ctrl #(
  parameter int   SETTLE_CYC  = 16,
  parameter int   TIMEOUT_CYC = 1024,
  parameter logic RST_SEL     = 1'b0,
  parameter int   CNT_W       = 11
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_req_i,
  input  logic sw_sel_i,
  input  logic alive_a_i,
  input  logic alive_b_i,
  output logic mux_sel_o,
  output logic cur_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       mux_sel_q, mux_sel_d;
  logic       cur_sel_q, cur_sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] alive_a_q, alive_b_q;
  logic       tgt_alive;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alive_a_q <= 2'b00;
      alive_b_q <= 2'b00;
    end else begin
      alive_a_q <= {alive_a_q[0], alive_a_i};
      alive_b_q <= {alive_b_q[0], alive_b_i};
    end
  end

  assign tgt_alive = sel_q ? alive_b_q[1] : alive_a_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= RST_SEL;
      mux_sel_q <= RST_SEL;
      cur_sel_q <= RST_SEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      mux_sel_q <= mux_sel_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    mux_sel_d = mux_sel_q;
    cur_sel_d = cur_sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sw_req_i) begin
          if (sw_sel_i == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = sw_sel_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A target that becomes alive on the timeout cycle still wins.
        if (tgt_alive) begin
          mux_sel_d = sel_q;
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        // The select cycle itself counts, so busy spans exactly SETTLE_CYC cycles.
        if (cnt_q == CNT_W'(SETTLE_CYC - 2)) begin
          cnt_d     = '0;
          cur_sel_d = sel_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mux_sel_o = mux_sel_q;
  assign cur_sel_o = cur_sel_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_crg_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_crg_clk_switch_ctrl : scoreboard bench for the clock-switch sequencer
// Revision: 1.0
// ============================================================================
module tb_crg_clk_switch_ctrl;

  localparam int   SETTLE_CYC  = 16;
  localparam int   TIMEOUT_CYC = 8;
  localparam logic RST_SEL     = 1'b0;
  localparam int   CNT_W       = 11;

  logic clk = 1'b0;
  logic rst_n, sw_req, sw_sel, alive_a, alive_b;
  logic mux_sel, cur_sel, busy, done, err;

  crg_clk_switch_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .RST_SEL    (RST_SEL),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sw_req_i (sw_req),
    .sw_sel_i (sw_sel),
    .alive_a_i(alive_a),
    .alive_b_i(alive_b),
    .mux_sel_o(mux_sel),
    .cur_sel_o(cur_sel),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    bit sel;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done || err) begin
        check_eq("done_err_excl", {31'd0, done & err}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_evt", sb.size(), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("evt_kind", {31'd0, err}, {31'd0, e.is_err});
          check_eq("evt_cyc", cyc, e.cyc);
          check_eq("evt_cur_sel", {31'd0, cur_sel}, {31'd0, e.sel});
          check_eq("evt_mux_sel", {31'd0, mux_sel}, {31'd0, e.sel});
          check_eq("evt_busy", {31'd0, busy}, 32'd0);
        end
      end
      if (!busy) check_eq("mux_eq_cur", {31'd0, mux_sel}, {31'd0, cur_sel});
    end
  end

  task automatic push(input bit is_err, input bit sel, input int at);
    exp_t e;
    e.is_err = is_err;
    e.sel    = sel;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_eq("drain", sb.size(), 32'd0);
  endtask

  // Issue a request at this negedge, then measure how many cycles busy stays high.
  task automatic switch_and_measure(input bit sel, output int busy_len, output logic mux_k0,
                                    output logic mux_k1);
    busy_len = 0;
    mux_k0   = 1'bx;
    mux_k1   = 1'bx;
    sw_req   = 1'b1;
    sw_sel   = sel;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      sw_req = 1'b0;
      if (k == 0) mux_k0 = mux_sel;
      if (k == 1) mux_k1 = mux_sel;
      if (busy) busy_len++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   blen;
    logic m0, m1;
    int   c;

    rst_n = 1'b0; sw_req = 1'b0; sw_sel = 1'b0; alive_a = 1'b0; alive_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mux_sel", {31'd0, mux_sel}, {31'd0, RST_SEL});
    check_eq("rst_cur_sel", {31'd0, cur_sel}, {31'd0, RST_SEL});
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // no-op request to the current source
    c = cyc; push(1'b0, 1'b0, c + 1);
    sw_req = 1'b1; sw_sel = 1'b0;
    @(negedge clk);
    sw_req = 1'b0;
    check_eq("noop_done", {31'd0, done}, 32'd1);
    check_eq("noop_busy", {31'd0, busy}, 32'd0);
    check_eq("noop_mux", {31'd0, mux_sel}, 32'd0);
    drain();

    // 0 -> 1 with target already alive
    alive_b = 1'b1;
    repeat (3) @(negedge clk);
    c = cyc; push(1'b0, 1'b1, c + 1 + SETTLE_CYC);
    switch_and_measure(1'b1, blen, m0, m1);
    check_eq("sw1_mux_k0", {31'd0, m0}, 32'd0);
    check_eq("sw1_mux_k1", {31'd0, m1}, 32'd1);
    check_eq("sw1_busy_len", blen, SETTLE_CYC);
    drain();

    // 1 -> 0 with clk_a dead: timeout
    c = cyc; push(1'b1, 1'b1, c + 1 + TIMEOUT_CYC);
    switch_and_measure(1'b0, blen, m0, m1);
    check_eq("to_busy_len", blen, TIMEOUT_CYC);
    check_eq("to_mux_after", {31'd0, mux_sel}, 32'd1);
    check_eq("to_cur_after", {31'd0, cur_sel}, 32'd1);
    drain();

    // 1 -> 0, clk_a comes alive 5 cycles later; extra requests while busy are ignored
    c = cyc; push(1'b0, 1'b0, c + 23);
    sw_req = 1'b1; sw_sel = 1'b0;
    @(negedge clk);
    sw_req = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3)  begin sw_req = 1'b1; sw_sel = 1'b1; end
      if (k == 4)  sw_req = 1'b0;
      if (k == 5)  alive_a = 1'b1;
      if (k == 7)  check_eq("late_mux_hold", {31'd0, mux_sel}, 32'd1);
      if (k == 8)  check_eq("late_mux_flip", {31'd0, mux_sel}, 32'd0);
      if (k == 12) begin sw_req = 1'b1; sw_sel = 1'b1; end
      if (k == 13) sw_req = 1'b0;
      if (k == 14) check_eq("late_busy", {31'd0, busy}, 32'd1);
    end
    drain();
    check_eq("late_cur", {31'd0, cur_sel}, 32'd0);

    // reset asserted during SETTLE of 0 -> 1
    c = cyc; push(1'b0, 1'b1, c + 1 + SETTLE_CYC);
    sw_req = 1'b1; sw_sel = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_mux", {31'd0, mux_sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("mid_rst_mux", {31'd0, mux_sel}, {31'd0, RST_SEL});
    check_eq("mid_rst_cur", {31'd0, cur_sel}, {31'd0, RST_SEL});
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done | err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    alive_b = 1'b0;
    repeat (4) @(negedge clk);

    // target alive exactly on the timeout cycle: alive wins
    c = cyc; push(1'b0, 1'b1, c + 1 + TIMEOUT_CYC + SETTLE_CYC - 1);
    sw_req = 1'b1; sw_sel = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) alive_b = 1'b1;
      if (k == 9) check_eq("tw_mux_flip", {31'd0, mux_sel}, 32'd1);
    end
    drain();

    // back-to-back: 1 -> 0, then 0 -> 1 issued on the done cycle
    c = cyc; push(1'b0, 1'b0, c + 1 + SETTLE_CYC);
    sw_req = 1'b1; sw_sel = 1'b0;
    @(negedge clk);
    sw_req = 1'b0;
    for (int k = 2; k <= 50; k++) begin
      @(negedge clk);
      if (cyc == c + 1 + SETTLE_CYC) break;
    end
    check_eq("b2b_done1", {31'd0, done}, 32'd1);
    push(1'b0, 1'b1, cyc + 1 + SETTLE_CYC);
    sw_req = 1'b1; sw_sel = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    check_eq("b2b_busy2", {31'd0, busy}, 32'd1);
    drain();
    check_eq("b2b_cur", {31'd0, cur_sel}, 32'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
